regfile_sb: RTL
===============

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL provide parameter XLEN, default 32: data width in bits.
REQ-002 SHALL provide parameter NREG, default 32: number of architectural registers, power of 2, at least 4.
REQ-003 SHALL provide parameter NRD, default 2: number of read ports, 1 to 4.
REQ-004 SHALL provide localparam AW = log2(NREG): register address width.
REQ-005 SHALL have one clock and a synchronous, active-high reset.
REQ-006 SHALL provide port clk, input, 1 bit: sole clock; all state updates on the rising edge.
REQ-007 SHALL provide port rst, input, 1 bit: synchronous active-high reset.
REQ-008 SHALL provide port rd_en, input, NRD bits: per-port read enable.
REQ-009 SHALL provide port rd_addr, input, NRD*AW bits: per-port read address; port k occupies slice [k*AW +: AW].
REQ-010 SHALL provide port rd_data, output, NRD*XLEN bits: per-port combinational read data.
REQ-011 SHALL provide port rd_busy, output, NRD bits: addressed register has a write outstanding.
REQ-012 SHALL provide port wr_en, input, 1 bit: writeback enable.
REQ-013 SHALL provide port wr_addr, input, AW bits: writeback address.
REQ-014 SHALL provide port wr_data, input, XLEN bits: writeback data.
REQ-015 SHALL provide port iss_en, input, 1 bit: mark a destination register pending at issue.
REQ-016 SHALL provide port iss_addr, input, AW bits: destination address to mark pending.
REQ-017 SHALL provide port clr_req, input, 1 bit: request a full register sweep to zero.
REQ-018 SHALL provide port clr_busy, output, 1 bit: sweep in progress.

Function
REQ-019 SHALL always read register 0 as zero, SHALL never write it, and SHALL never mark it pending.
REQ-020 SHALL drive rd_data[k] to 0 when rd_en[k]=0 or the port k address is 0.
REQ-021 SHALL bypass writes to reads: when wr_en=1, wr_addr is nonzero and equal to the port k address, and the FSM is IDLE, rd_data[k] SHALL equal wr_data in the same cycle (write-first).
REQ-022 SHALL otherwise drive rd_data[k] from the stored register contents.
REQ-023 SHALL drive rd_busy[k] = rd_en[k] AND pend[addr] AND NOT (a bypassing write to the same address this cycle).
REQ-024 SHALL store wr_data into the register at wr_addr on the next edge when wr_en=1, wr_addr≠0 and the FSM is IDLE.
REQ-025 SHALL set pend[iss_addr] on the next edge when iss_en=1, iss_addr≠0 and the FSM is IDLE.
REQ-026 SHALL clear pend[wr_addr] on the next edge when a write is accepted.
REQ-027 SHALL let issue win over writeback (pend stays 1) when both target the same address in the same cycle.
REQ-028 SHALL implement a two-state FSM, IDLE and SWEEP, with an index counter idx of width AW.
REQ-029 SHALL, in IDLE with clr_req=1, go to SWEEP and load idx=1; in that cycle it SHALL ignore wr_en and iss_en.
REQ-030 SHALL, in SWEEP, each cycle zero the register at idx, clear pend[idx], and increment idx.
REQ-031 SHALL return from SWEEP to IDLE after processing idx = NREG-1; the sweep lasts NREG-1 cycles.
REQ-032 SHALL drive clr_busy=1 in the request cycle and throughout SWEEP.
REQ-033 SHALL, while clr_busy=1, drop wr_en and iss_en, disable bypass, and still serve reads from stored contents.
REQ-034 SHALL ignore clr_req while in SWEEP.
REQ-035 SHALL let idx wrap to 0 only on the exit transition, and SHALL not use it in IDLE.

Reset
REQ-036 SHALL, on rst=1 at the rising edge, zero all registers and all pend bits, set the FSM to IDLE and idx to 0, with priority over every other input.
REQ-037 SHALL abort a sweep in progress when rst is asserted; clr_busy SHALL be 0 in the cycle after reset.
REQ-038 SHALL hold rd_busy at 0 after reset until the first accepted issue, and rd_data SHALL read 0 for all addresses.

Structure
REQ-039 SHALL place the FSM state enum (IDLE, SWEEP) and the default XLEN/NREG constants in shared package regfile_pkg.
REQ-040 SHALL contain one sub-module, regfile_sweep, holding the FSM, idx counter and clr_busy; the storage, pend vector, bypass and read muxes SHALL remain in regfile_sb.

Verification
REQ-041 SHALL cover: write x5=0xDEADBEEF while port0 reads x5 in the same cycle -> rd_data0=0xDEADBEEF that cycle and 0xDEADBEEF from storage on the next cycle.
REQ-042 SHALL cover: issue x7, then read x7 -> rd_busy0=1; write x7=0x12 -> rd_busy0=0 in the write cycle (bypass) and after it.
REQ-043 SHALL cover: same-cycle iss_addr=wr_addr=9 -> x9 gets wr_data and pend[9] remains 1.
REQ-044 SHALL cover: write x0=0xFFFFFFFF and issue x0 -> reads of x0 return 0 and rd_busy=0.
REQ-045 SHALL cover: fill x1..x31 with nonzero values, pulse clr_req -> clr_busy high for 32 cycles (request cycle plus 31 sweep cycles), a write during SWEEP is dropped, and all registers read 0 afterwards.
REQ-046 SHALL cover: assert rst mid-sweep at idx=10 -> next cycle clr_busy=0 and all registers and pend bits are 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file: sweep FSM states and
// default geometry.
package regfile_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } sweep_state_e;

    localparam int DEF_XLEN = 32;
    localparam int DEF_NREG = 32;

endpackage

// File: rtl/regfile_sweep.sv
// Clear-sweep controller: walks idx from 1 to NREG-1, one register per cycle,
// and raises clr_busy_o from the request cycle until the walk ends.
module regfile_sweep
    import regfile_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req_i,
    output logic          clr_busy_o,
    output logic          sweep_o,
    output logic [AW-1:0] idx_o,
    output logic          state_o
);

    sweep_state_e  state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        clr_busy_o = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (clr_req_i) begin
                    state_d    = ST_SWEEP;
                    idx_d      = AW'(1);
                    clr_busy_o = 1'b1;
                end
            end
            ST_SWEEP: begin
                // Register 0 is never stored, so the walk starts at 1 and the
                // increment past NREG-1 wraps idx back to 0 on exit.
                clr_busy_o = 1'b1;
                idx_d      = idx_q + AW'(1);
                if (&idx_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign sweep_o = (state_q == ST_SWEEP);
    assign idx_o   = idx_q;
    assign state_o = state_q;

    a_sweep_idx_nonzero: assert property (@(posedge clk) disable iff (rst)
        (state_q == ST_SWEEP) |-> (idx_q != '0));

endmodule

// File: rtl/regfile_sb.sv
// Register file with a per-register pending (scoreboard) bit, write-first
// bypass on the read ports, and a multi-cycle clear sweep.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int NREG = DEF_NREG,
    parameter int NRD  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD-1:0]      rd_en,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                clr_req,
    output logic                clr_busy
);

    if (NREG < 4 || (NREG & (NREG - 1)) != 0) begin : g_bad_nreg
        $error("regfile_sb: NREG must be a power of two, at least 4");
    end
    if (NRD < 1 || NRD > 4) begin : g_bad_nrd
        $error("regfile_sb: NRD must be between 1 and 4");
    end

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] pend_q, pend_d;

    logic            sweep_active;
    logic            sweep_state;
    logic [AW-1:0]   sweep_idx;
    logic            wr_ok;
    logic            iss_ok;

    regfile_sweep #(
        .AW(AW)
    ) u_sweep (
        .clk       (clk),
        .rst       (rst),
        .clr_req_i (clr_req),
        .clr_busy_o(clr_busy),
        .sweep_o   (sweep_active),
        .idx_o     (sweep_idx),
        .state_o   (sweep_state)
    );

    // clr_busy covers the request cycle as well as the sweep, so gating on it
    // drops writes/issues and disables the bypass in both.
    assign wr_ok  = wr_en  && (wr_addr  != '0) && !clr_busy;
    assign iss_ok = iss_en && (iss_addr != '0) && !clr_busy;

    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (sweep_active) begin
            regs_d[sweep_idx] = '0;
            pend_d[sweep_idx] = 1'b0;
        end
        if (wr_ok) begin
            regs_d[wr_addr] = wr_data;
            pend_d[wr_addr] = 1'b0;
        end
        // Issue after writeback so a same-address pair leaves the bit set.
        if (iss_ok) begin
            pend_d[iss_addr] = 1'b1;
        end
        regs_d[0] = '0;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] addr;
        logic          byp;

        assign addr = rd_addr[k*AW +: AW];
        assign byp  = wr_ok && (wr_addr == addr);
        assign rd_data[k*XLEN +: XLEN] = (!rd_en[k] || addr == '0) ? '0 :
                                         byp ? wr_data : regs_q[addr];
        assign rd_busy[k] = rd_en[k] && pend_q[addr] && !byp;
    end

    a_x0_zero: assert property (@(posedge clk) disable iff (rst)
        (regs_q[0] == '0) && !pend_q[0]);
    a_busy_in_sweep: assert property (@(posedge clk) disable iff (rst)
        (sweep_state == ST_SWEEP) |-> clr_busy);

endmodule
